// File: rtl/calc_entry_sequencer.sv
// Keypad calculator sequencer: assembles two decimal operands and an operator
// from debounced key presses, then runs add/sub (1 cycle) or shift-add multiply.
module calc_entry_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_p,
   input  logic [3:0]           key_value,
   input  logic                 key_valid,
   output logic [2*WIDTH-1:0]   disp_value,
   output logic [1:0]           op_code,
   output logic [2:0]           state,
   output logic                 neg,
   output logic                 ovf,
   output logic                 busy,
   output logic                 done
);

   localparam int RW = 2 * WIDTH;
   localparam int XW = WIDTH + 4;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] OP_ADD = 2'd1;
   localparam logic [1:0] OP_SUB = 2'd2;
   localparam logic [1:0] OP_MUL = 2'd3;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_EXEC = 3'd2,
      S_DONE = 3'd3
   } state_t;

   state_t            st, st_n;
   logic              key_valid_d;
   logic [WIDTH-1:0]  a_q, a_n, b_q, b_n, mplier_q, mplier_n;
   logic [RW-1:0]     result_q, result_n, acc_q, acc_n, mcand_q, mcand_n;
   logic [1:0]        op_q, op_n;
   logic              neg_q, neg_n, ovf_q, ovf_n, done_q, done_n;
   logic [CW-1:0]     cnt_q, cnt_n;

   logic              key_event, is_digit, is_op, is_eq, is_clr;
   logic [1:0]        op_key;
   logic [XW-1:0]     a_wide, b_wide;
   logic [RW-1:0]     acc_step, addsub_res;
   logic              addsub_neg;

   assign key_event = key_valid & ~key_valid_d;
   assign is_digit  = (key_value <= 4'd9);
   assign is_op     = (key_value == 4'hA) || (key_value == 4'hB) || (key_value == 4'hC);
   assign is_eq     = (key_value == 4'hD);
   assign is_clr    = (key_value == 4'hE);
   assign op_key    = 2'(key_value - 4'd9);

   // Digit append is evaluated wide so an out-of-range result can be rejected
   assign a_wide   = XW'(a_q) * XW'(10) + XW'(key_value);
   assign b_wide   = XW'(b_q) * XW'(10) + XW'(key_value);
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      addsub_res = '0;
      addsub_neg = 1'b0;
      if (op_q == OP_SUB) begin
         if (a_q >= b_q) begin
            addsub_res = RW'(a_q - b_q);
         end else begin
            addsub_res = RW'(b_q - a_q);
            addsub_neg = 1'b1;
         end
      end else begin
         addsub_res = RW'(a_q) + RW'(b_q);
      end
   end

   always_comb begin
      st_n     = st;
      a_n      = a_q;
      b_n      = b_q;
      op_n     = op_q;
      result_n = result_q;
      neg_n    = neg_q;
      ovf_n    = ovf_q;
      done_n   = 1'b0;
      acc_n    = acc_q;
      mcand_n  = mcand_q;
      mplier_n = mplier_q;
      cnt_n    = cnt_q;
      if (key_event && is_clr && st != S_EXEC) begin
         st_n     = S_A;
         a_n      = '0;
         b_n      = '0;
         op_n     = '0;
         result_n = '0;
         neg_n    = 1'b0;
         ovf_n    = 1'b0;
      end else begin
         case (st)
            S_A: if (key_event) begin
               if (is_digit) begin
                  if (a_wide[XW-1:WIDTH] == '0) a_n = a_wide[WIDTH-1:0];
               end else if (is_op) begin
                  op_n = op_key;
                  b_n  = '0;
                  st_n = S_B;
               end else if (is_eq) begin
                  result_n = RW'(a_q);
                  neg_n    = 1'b0;
                  ovf_n    = 1'b0;
                  done_n   = 1'b1;
                  st_n     = S_DONE;
               end
            end
            S_B: if (key_event) begin
               if (is_digit) begin
                  if (b_wide[XW-1:WIDTH] == '0) b_n = b_wide[WIDTH-1:0];
               end else if (is_op) begin
                  op_n = op_key;
               end else if (is_eq) begin
                  acc_n    = '0;
                  mcand_n  = RW'(a_q);
                  mplier_n = b_q;
                  cnt_n    = '0;
                  st_n     = S_EXEC;
               end
            end
            S_EXEC: begin
               if (op_q == OP_MUL) begin
                  acc_n    = acc_step;
                  mcand_n  = mcand_q << 1;
                  mplier_n = mplier_q >> 1;
                  cnt_n    = cnt_q + 1'b1;
                  if (cnt_q == CW'(WIDTH - 1)) begin
                     result_n = acc_step;
                     neg_n    = 1'b0;
                     ovf_n    = (acc_step[RW-1:WIDTH] != '0);
                     done_n   = 1'b1;
                     st_n     = S_DONE;
                  end
               end else begin
                  result_n = addsub_res;
                  neg_n    = addsub_neg;
                  ovf_n    = (addsub_res[RW-1:WIDTH] != '0);
                  done_n   = 1'b1;
                  st_n     = S_DONE;
               end
            end
            S_DONE: if (key_event) begin
               if (is_digit) begin
                  a_n   = WIDTH'(key_value);
                  b_n   = '0;
                  op_n  = '0;
                  neg_n = 1'b0;
                  ovf_n = 1'b0;
                  st_n  = S_A;
               end else if (is_op && !ovf_q && !neg_q) begin
                  a_n  = result_q[WIDTH-1:0];
                  op_n = op_key;
                  b_n  = '0;
                  st_n = S_B;
               end
            end
            default: st_n = S_A;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         st          <= S_A;
         key_valid_d <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         result_q    <= '0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
         done_q      <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
      end else begin
         st          <= st_n;
         key_valid_d <= key_valid;
         a_q         <= a_n;
         b_q         <= b_n;
         op_q        <= op_n;
         result_q    <= result_n;
         neg_q       <= neg_n;
         ovf_q       <= ovf_n;
         done_q      <= done_n;
         acc_q       <= acc_n;
         mcand_q     <= mcand_n;
         mplier_q    <= mplier_n;
         cnt_q       <= cnt_n;
      end
   end

   always_comb begin
      case (st)
         S_A:          disp_value = RW'(a_q);
         S_B, S_EXEC:  disp_value = RW'(b_q);
         default:      disp_value = result_q;
      endcase
   end

   assign state   = st;
   assign op_code = op_q;
   assign neg     = neg_q;
   assign ovf     = ovf_q;
   assign busy    = (st == S_EXEC);
   assign done    = done_q;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Bench for calc_entry_sequencer: key-press vector table with post-key state
// checks, plus a scoreboard matching each done pulse to its '=' press.
module tb_calc_entry_sequencer;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset_p;
   logic [3:0]     key_value;
   logic           key_valid;
   logic [2*W-1:0] disp_value;
   logic [1:0]     op_code;
   logic [2:0]     state;
   logic           neg, ovf, busy, done;

   calc_entry_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset_p(reset_p), .key_value(key_value), .key_valid(key_valid),
      .disp_value(disp_value), .op_code(op_code), .state(state), .neg(neg),
      .ovf(ovf), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      logic [15:0] disp;
      logic        neg;
      logic        ovf;
      logic [1:0]  op;
      int          cyc;
      int          busy;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [3:0]  key;
      int          hold;
      int          gap;
      bit          check;
      logic [2:0]  st;
      logic [15:0] disp;
      logic [1:0]  op;
      logic        neg;
      logic        ovf;
      bit          eq;
      int          lat;
      int          bsy;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t k(input logic [3:0] key, input logic [2:0] st,
                              input logic [15:0] disp, input logic [1:0] op,
                              input logic n, input logic o);
      vec_t v;
      v.key = key; v.hold = 5; v.gap = 2; v.check = 1'b1;
      v.st = st; v.disp = disp; v.op = op; v.neg = n; v.ovf = o;
      v.eq = 1'b0; v.lat = 0; v.bsy = 0;
      return v;
   endfunction

   function automatic vec_t eqk(input logic [15:0] disp, input logic [1:0] op,
                                input logic n, input logic o, input int lat, input int bsy);
      vec_t v;
      v = k(4'hD, 3'd3, disp, op, n, o);
      v.eq = 1'b1; v.lat = lat; v.bsy = bsy;
      v.gap = lat + 2;
      return v;
   endfunction

   // Monitor: every done pulse must match the oldest pending '=' expectation
   int   busy_cnt = 0;
   exp_t got;
   always @(negedge clk) begin
      if (reset_p) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
               got = sb.pop_front();
               chk("done_disp", 32'(disp_value), 32'(got.disp));
               chk("done_neg", 32'(neg), 32'(got.neg));
               chk("done_ovf", 32'(ovf), 32'(got.ovf));
               chk("done_op", 32'(op_code), 32'(got.op));
               chk("done_cycle", 32'(cyc), 32'(got.cyc));
               chk("busy_cycles", 32'(busy_cnt), 32'(got.busy));
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic press(input logic [3:0] key, input int hold, input int gap);
      @(posedge clk); #1;
      key_value = key;
      key_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1 key_valid = 1'b0;
      key_value = 4'hF;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [2:0] st, input logic [15:0] disp,
                            input logic [1:0] op, input logic n, input logic o);
      chk({tag, "_state"}, 32'(state), 32'(st));
      chk({tag, "_disp"}, 32'(disp_value), 32'(disp));
      chk({tag, "_op"}, 32'(op_code), 32'(op));
      chk({tag, "_neg"}, 32'(neg), 32'(n));
      chk({tag, "_ovf"}, 32'(ovf), 32'(o));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      vec_t v;
      reset_p = 1'b1; key_valid = 1'b0; key_value = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset", 3'd0, 16'd0, 2'd0, 1'b0, 1'b0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      reset_p = 1'b0;

      // 12 + 34 = 46
      vecs.push_back(k(4'h1, 0, 1, 0, 0, 0));
      vecs.push_back(k(4'h2, 0, 12, 0, 0, 0));
      vecs.push_back(k(4'hA, 1, 0, 1, 0, 0));
      vecs.push_back(k(4'h3, 1, 3, 1, 0, 0));
      vecs.push_back(k(4'h4, 1, 34, 1, 0, 0));
      vecs.push_back(eqk(46, 1, 0, 0, 2, 1));
      // 5 - 9 -> 4 negative, op key then ignored
      vecs.push_back(k(4'h5, 0, 5, 0, 0, 0));
      vecs.push_back(k(4'hB, 1, 0, 2, 0, 0));
      vecs.push_back(k(4'h9, 1, 9, 2, 0, 0));
      vecs.push_back(eqk(4, 2, 1, 0, 2, 1));
      vecs.push_back(k(4'hA, 3, 4, 2, 1, 0));
      // 255 * 255 -> 65025 overflow, op key then ignored
      vecs.push_back(k(4'h2, 0, 2, 0, 0, 0));
      vecs.push_back(k(4'h5, 0, 25, 0, 0, 0));
      vecs.push_back(k(4'h5, 0, 255, 0, 0, 0));
      vecs.push_back(k(4'hC, 1, 0, 3, 0, 0));
      vecs.push_back(k(4'h2, 1, 2, 3, 0, 0));
      vecs.push_back(k(4'h5, 1, 25, 3, 0, 0));
      vecs.push_back(k(4'h5, 1, 255, 3, 0, 0));
      vecs.push_back(eqk(65025, 3, 0, 1, 9, 8));
      vecs.push_back(k(4'hA, 3, 65025, 3, 0, 1));
      // digit overflow drop, long hold yields one digit
      vecs.push_back(k(4'h2, 0, 2, 0, 0, 0));
      vecs.push_back(k(4'h5, 0, 25, 0, 0, 0));
      vecs.push_back(k(4'h6, 0, 25, 0, 0, 0));
      v = k(4'h1, 0, 251, 0, 0, 0); v.hold = 20; vecs.push_back(v);
      vecs.push_back(k(4'hE, 0, 0, 0, 0, 0));
      // chain: 10*3 = 30, then +5 = 35, then new digit
      vecs.push_back(k(4'h1, 0, 1, 0, 0, 0));
      vecs.push_back(k(4'h0, 0, 10, 0, 0, 0));
      vecs.push_back(k(4'hC, 1, 0, 3, 0, 0));
      vecs.push_back(k(4'h3, 1, 3, 3, 0, 0));
      vecs.push_back(eqk(30, 3, 0, 0, 9, 8));
      vecs.push_back(k(4'hA, 1, 0, 1, 0, 0));
      vecs.push_back(k(4'h5, 1, 5, 1, 0, 0));
      vecs.push_back(eqk(35, 1, 0, 0, 2, 1));
      vecs.push_back(k(4'h7, 0, 7, 0, 0, 0));
      vecs.push_back(eqk(7, 0, 0, 0, 1, 0));
      vecs.push_back(k(4'hF, 3, 7, 0, 0, 0));
      // 9 - 9 = 0 non-negative
      vecs.push_back(k(4'h0, 0, 0, 0, 0, 0));
      vecs.push_back(k(4'h9, 0, 9, 0, 0, 0));
      vecs.push_back(k(4'hB, 1, 0, 2, 0, 0));
      vecs.push_back(k(4'h9, 1, 9, 2, 0, 0));
      vecs.push_back(eqk(0, 2, 0, 0, 2, 1));
      // 200 + 100 = 300 overflows the operand range
      vecs.push_back(k(4'h2, 0, 2, 0, 0, 0));
      vecs.push_back(k(4'h0, 0, 20, 0, 0, 0));
      vecs.push_back(k(4'h0, 0, 200, 0, 0, 0));
      vecs.push_back(k(4'hA, 1, 0, 1, 0, 0));
      vecs.push_back(k(4'h1, 1, 1, 1, 0, 0));
      vecs.push_back(k(4'h0, 1, 10, 1, 0, 0));
      vecs.push_back(k(4'h0, 1, 100, 1, 0, 0));
      vecs.push_back(eqk(300, 1, 0, 1, 2, 1));
      vecs.push_back(k(4'hB, 3, 300, 1, 0, 1));
      // 9 * 9 with clear pressed while busy
      vecs.push_back(k(4'h9, 0, 9, 0, 0, 0));
      vecs.push_back(k(4'hC, 1, 0, 3, 0, 0));
      vecs.push_back(k(4'h9, 1, 9, 3, 0, 0));
      v = eqk(81, 3, 0, 0, 9, 8); v.hold = 1; v.gap = 0; v.check = 1'b0; vecs.push_back(v);
      v = k(4'hE, 3, 81, 3, 0, 0); v.hold = 1; v.gap = 10; vecs.push_back(v);
      vecs.push_back(k(4'hE, 0, 0, 0, 0, 0));

      foreach (vecs[i]) begin
         v = vecs[i];
         if (v.eq) begin
            e.disp = v.disp; e.neg = v.neg; e.ovf = v.ovf; e.op = v.op;
            e.cyc = cyc + 1 + v.lat; e.busy = v.bsy;
            sb.push_back(e);
         end
         press(v.key, v.hold, v.gap);
         if (v.check) check_all($sformatf("vec%0d", i), v.st, v.disp, v.op, v.neg, v.ovf);
      end

      // reset mid-entry returns everything to reset values next cycle
      press(4'h4, 3, 1);
      press(4'hA, 3, 1);
      press(4'h5, 3, 1);
      check_all("pre_rst", 3'd1, 16'd5, 2'd1, 1'b0, 1'b0);
      reset_p = 1'b1;
      @(posedge clk); #1;
      reset_p = 1'b0;
      check_all("mid_rst", 3'd0, 16'd0, 2'd0, 1'b0, 1'b0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      press(4'h3, 3, 2);
      check_all("post_rst", 3'd0, 16'd3, 2'd0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
